// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if
//   Request/result bundle for shift_sequencer.
//
//   Handshake semantics, identical on both channels:
//     A transfer happens on a rising clock edge where valid and ready are
//     both high. The producer holds valid and its payload stable until that
//     edge. The consumer may raise or lower ready at any time.
//
//   Request channel  : in_valid, in_ready, in_data[31:0], in_shamt[4:0],
//                      in_op[1:0] (00 SLL, 01 SRA, 10 SRL, 11 pass-through)
//   Result channel   : out_valid, out_ready, out_data[31:0]
//
//   Modports:
//     master - issue logic / testbench side (drives requests, sinks results)
//     slave  - the shift sequencer itself
interface shift_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-cycle shift controller. A request is captured into a working
//   register and shifted by one stage (16, 8, 4, 2, 1 bits, in that order)
//   per clock, then the result is offered on the result channel.
//
//   Ports:
//     clock     - rising-edge clock
//     reset     - asynchronous, active-low reset
//     bus       - shift_sequencer_if.slave (request and result handshakes)
//     busy      - high in any state other than IDLE
//     dbg_state - current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
//   Build option:
//     SHIFT_SEQ_SKIP_EN - when defined, only the stages whose shamt bit is
//       set are visited (highest first), and a zero effective amount goes
//       straight from IDLE to DONE. When undefined, all five stages are
//       always visited, giving a constant latency of 5 edges.
module shift_sequencer (
  input  logic                   clock,
  input  logic                   reset,
  shift_sequencer_if.slave       bus,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_work;
  logic [1:0]  r_op;
  logic [4:0]  r_shamt;
  logic [4:0]  w_eff_shamt;
  logic [4:0]  w_amt;
  logic        w_apply;
  logic        w_last;
  logic [31:0] w_shifted;
`ifdef SHIFT_SEQ_SKIP_EN
  logic [2:0]  w_top;
  logic [4:0]  w_rem;
`else
  logic [2:0]  r_stage;
`endif

  // Op 11 is a pass-through: it is treated as a zero shift amount.
  assign w_eff_shamt = (bus.in_op == 2'b11) ? 5'd0 : bus.in_shamt;

  // Stage selection. w_amt is both the shift distance of the current stage
  // and the mask of the shamt bit that stage consumes.
  always_comb begin
    w_amt   = 5'd0;
    w_apply = 1'b0;
    w_last  = 1'b0;
`ifdef SHIFT_SEQ_SKIP_EN
    w_top = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (r_shamt[i]) w_top = 3'(i);
    end
    w_amt   = 5'd1 << w_top;
    w_apply = 1'b1;
    w_rem   = r_shamt & ~w_amt;
    w_last  = (w_rem == 5'd0);
`else
    case (r_stage)
      3'd0:    begin w_amt = 5'd16; w_apply = r_shamt[4]; end
      3'd1:    begin w_amt = 5'd8;  w_apply = r_shamt[3]; end
      3'd2:    begin w_amt = 5'd4;  w_apply = r_shamt[2]; end
      3'd3:    begin w_amt = 5'd2;  w_apply = r_shamt[1]; end
      default: begin w_amt = 5'd1;  w_apply = r_shamt[0]; end
    endcase
    w_last = (r_stage == 3'd4);
`endif
  end

  // One stage of the shift datapath; SRA replicates bit 31 of the current
  // working value, not of the original operand (they are the same anyway).
  always_comb begin
    w_shifted = r_work;
    case (r_op)
      2'b00:   w_shifted = r_work << w_amt;
      2'b01:   w_shifted = 32'($signed(r_work) >>> w_amt);
      2'b10:   w_shifted = r_work >> w_amt;
      default: w_shifted = r_work;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
`ifdef SHIFT_SEQ_SKIP_EN
          w_state_next = (w_eff_shamt == 5'd0) ? ST_DONE : ST_SHIFT;
`else
          w_state_next = ST_SHIFT;
`endif
        end
      end
      ST_SHIFT: if (w_last) w_state_next = ST_DONE;
      ST_DONE:  if (bus.out_ready) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_work  <= 32'd0;
      r_op    <= 2'd0;
      r_shamt <= 5'd0;
`ifndef SHIFT_SEQ_SKIP_EN
      r_stage <= 3'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_work  <= bus.in_data;
            r_op    <= bus.in_op;
            r_shamt <= w_eff_shamt;
`ifndef SHIFT_SEQ_SKIP_EN
            r_stage <= 3'd0;
`endif
          end
        end
        ST_SHIFT: begin
          if (w_apply) r_work <= w_shifted;
`ifdef SHIFT_SEQ_SKIP_EN
          r_shamt <= w_rem;
`else
          r_stage <= r_stage + 3'd1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_data  = r_work;
  assign busy          = (r_state != ST_IDLE);
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        clock;
  logic        reset;
  logic        busy;
  logic [1:0]  dbg_state;

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_result(input logic [31:0] d, input logic [1:0] op,
                                               input logic [4:0] sh);
    case (op)
      2'b00:   return d << sh;
      2'b01:   return d[31] ? ~((~d) >> sh) : (d >> sh);
      2'b10:   return d >> sh;
      default: return d;
    endcase
  endfunction

  // Edges after the accept edge until out_valid is seen.
  function automatic int model_latency(input logic [1:0] op, input logic [4:0] sh);
`ifdef SHIFT_SEQ_SKIP_EN
    if (op == 2'b11) return 0;
    return $countones(sh);
`else
    return 5;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- driver ----------------
  // Issues one request, waits for the result, applies `hold` cycles of
  // backpressure (poking in_valid meanwhile), then consumes it. If
  // `collide` is set, in_valid is high on the consuming edge too.
  task automatic run_txn(input string tag, input logic [31:0] d, input logic [1:0] op,
                         input logic [4:0] sh, input int hold, input bit collide);
    int lat;
    logic [31:0] exp;
    check({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_op     = op;
    bus.in_shamt  = sh;
    bus.out_ready = 1'b0;
    exp_q.push_back(model_result(d, op, sh));
    tick();
    // inputs may change freely after acceptance
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    bus.in_op    = 2'($urandom_range(0, 3));
    bus.in_shamt = 5'($urandom_range(0, 31));
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(model_latency(op, sh)));
    exp = exp_q.pop_front();
    check({tag, ".data"}, bus.out_data, exp);
    check({tag, ".busy"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      tick();
      check({tag, ".hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({tag, ".hold_data"}, bus.out_data, exp);
      check({tag, ".hold_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = collide;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check({tag, ".consumed"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, ".idle_ready"}, {31'd0, bus.in_ready}, 32'd1);
    tick();
    check({tag, ".not_queued"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".in_ready"},  {31'd0, bus.in_ready},  32'd1);
    check({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, ".busy"},      {31'd0, busy},          32'd0);
    check({tag, ".out_data"},  bus.out_data,           32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_op     = '0;
    bus.in_shamt  = '0;
    bus.out_ready = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("rst_hold");
    reset = 1'b1;
    tick();
    check_reset_values("rst_rel");

    run_txn("sll31",   32'h0000_0001, 2'b00, 5'd31, 0, 1'b0);
    run_txn("sra4",    32'h8000_0000, 2'b01, 5'd4,  0, 1'b0);
    run_txn("srl4",    32'h8000_0000, 2'b10, 5'd4,  0, 1'b0);
    run_txn("bp10",    32'h8000_0000, 2'b01, 5'd4,  10, 1'b1);
    run_txn("sra31",   32'h8765_4321, 2'b01, 5'd31, 0, 1'b0);
    run_txn("sh0",     32'hDEAD_BEEF, 2'b00, 5'd0,  0, 1'b0);
    run_txn("sh17",    32'hA5A5_0F0F, 2'b10, 5'd17, 1, 1'b0);
    run_txn("op3",     32'h1234_5678, 2'b11, 5'd7,  0, 1'b0);

    // mid-operation reset
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_FFFF;
    bus.in_op    = 2'b00;
    bus.in_shamt = 5'd31;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_reset_values("mid_rst");
    tick();
    reset = 1'b1;
    tick();
    check_reset_values("mid_rel");
    run_txn("after_rst", 32'h0000_FFFF, 2'b10, 5'd8, 0, 1'b0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      run_txn($sformatf("rnd%0d", t), $urandom, 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 31)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // absolute time limit
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
